chess_input_conditioner: RTL and testbench

CHESS_INPUT_CONDITIONER -- requirements
Module: chess_input_conditioner

---
 rtl/chess_input_conditioner.sv | 123 ++++++++++++
 tb/tb_chess_input_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/chess_input_conditioner.sv
// Button front end for the chess clock: synchronises and debounces four raw
// buttons, turns debounced presses into single events and sequences the game.
module chess_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_switch,
  input  logic       btn_surr_p1,
  input  logic       btn_surr_p2,
  output logic       start,
  output logic       switch_turn,
  output logic       surrender_player1,
  output logic       surrender_player2,
  output logic [1:0] game_state
);

  localparam int NB = 4;
  localparam int B_START  = 0;
  localparam int B_SWITCH = 1;
  localparam int B_SURR1  = 2;
  localparam int B_SURR2  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_ENDED   = 2'b10
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] press;
  state_t        state;

  assign raw = {btn_surr_p2, btn_surr_p1, btn_switch, btn_start};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_q;

    // Counter only runs while the synced input disagrees with the accepted level.
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt     <= '0;
        level   <= 1'b0;
        level_q <= 1'b0;
      end else begin
        level_q <= level;
        if (sync2[i] == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= sync2[i];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[i] = level & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= S_IDLE;
      start             <= 1'b0;
      switch_turn       <= 1'b0;
      surrender_player1 <= 1'b0;
      surrender_player2 <= 1'b0;
    end else begin
      switch_turn       <= 1'b0;
      surrender_player1 <= 1'b0;
      surrender_player2 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press[B_START]) begin
            state <= S_RUNNING;
            start <= 1'b1;
          end
        end
        S_RUNNING: begin
          // Simultaneous surrenders cancel; a surrender always beats a switch.
          if (press[B_SURR1] && press[B_SURR2]) begin
            state <= S_RUNNING;
          end else if (press[B_SURR1]) begin
            surrender_player1 <= 1'b1;
            state             <= S_ENDED;
          end else if (press[B_SURR2]) begin
            surrender_player2 <= 1'b1;
            state             <= S_ENDED;
          end else if (press[B_SWITCH]) begin
            switch_turn <= 1'b1;
          end
        end
        S_ENDED: state <= S_ENDED;
        default: begin
          state <= S_IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_chess_input_conditioner.sv
// Scoreboard bench for chess_input_conditioner at DEBOUNCE_CYCLES=4: directed
// presses push expected events; a negedge monitor pops and compares them.
module tb_chess_input_conditioner;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  localparam logic [3:0] EV_START = 4'b1000;
  localparam logic [3:0] EV_SW    = 4'b0100;
  localparam logic [3:0] EV_P1    = 4'b0010;
  localparam logic [3:0] EV_P2    = 4'b0001;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_switch = 1'b0;
  logic       btn_surr_p1 = 1'b0;
  logic       btn_surr_p2 = 1'b0;
  logic       start;
  logic       switch_turn;
  logic       surrender_player1;
  logic       surrender_player2;
  logic [1:0] game_state;

  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  logic start_prev = 1'b0;
  exp_t sb[$];

  chess_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_start         (btn_start),
    .btn_switch        (btn_switch),
    .btn_surr_p1       (btn_surr_p1),
    .btn_surr_p2       (btn_surr_p2),
    .start             (start),
    .switch_turn       (switch_turn),
    .surrender_player1 (surrender_player1),
    .surrender_player2 (surrender_player2),
    .game_state        (game_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after edge N, so they are first sampled at N+1.
  task automatic expect_event(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.cyc  = edge_n + LAT;
    sb.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " start"}, int'(start), 0);
    check({tag, " pulses"}, int'({switch_turn, surrender_player1, surrender_player2}), 0);
    check({tag, " game_state"}, int'(game_state), 0);
  endtask

  // Monitor: every observed output event must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0] obs;
    exp_t       e;
    obs        = {start & ~start_prev, switch_turn, surrender_player1, surrender_player2};
    start_prev = start;
    if (obs != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected event", int'(obs), 0);
      end else begin
        e = sb.pop_front();
        check("event code", int'(obs), int'(e.code));
        check("event edge", edge_n, e.cyc);
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    check_idle_outputs("reset");
    reset = 1'b1;
    tick(2);

    // Switch and p2 surrender before start are dropped
    btn_switch  = 1'b1;
    btn_surr_p2 = 1'b1;
    tick(10);
    btn_switch  = 1'b0;
    btn_surr_p2 = 1'b0;
    tick(8);
    check("idle ignores presses game_state", int'(game_state), 0);
    check("idle ignores presses start", int'(start), 0);

    // Start button held 10 cycles: one transition to RUNNING
    btn_start = 1'b1;
    expect_event(EV_START);
    tick(10);
    btn_start = 1'b0;
    tick(8);
    check("running game_state", int'(game_state), 1);
    check("running start", int'(start), 1);

    // Bouncing switch never settles long enough
    for (int i = 0; i < 8; i++) begin
      btn_switch = (i % 2 == 0);
      tick(1);
    end
    btn_switch = 1'b0;
    tick(8);

    // Clean switch press held 8 cycles, then a second press
    for (int k = 0; k < 2; k++) begin
      btn_switch = 1'b1;
      expect_event(EV_SW);
      tick(8);
      btn_switch = 1'b0;
      tick(8);
    end
    check("after switches game_state", int'(game_state), 1);

    // Simultaneous surrenders cancel
    btn_surr_p1 = 1'b1;
    btn_surr_p2 = 1'b1;
    tick(8);
    btn_surr_p1 = 1'b0;
    btn_surr_p2 = 1'b0;
    tick(8);
    check("dual surrender game_state", int'(game_state), 1);

    // Start pressed again while RUNNING is ignored
    btn_start = 1'b1;
    tick(8);
    btn_start = 1'b0;
    tick(8);

    // Player-2 surrender ends the game
    btn_surr_p2 = 1'b1;
    expect_event(EV_P2);
    tick(8);
    btn_surr_p2 = 1'b0;
    tick(8);
    check("p2 surrender game_state", int'(game_state), 2);

    // ENDED drops switch and p1 surrender
    btn_switch = 1'b1;
    tick(8);
    btn_switch = 1'b0;
    btn_surr_p1 = 1'b1;
    tick(8);
    btn_surr_p1 = 1'b0;
    tick(8);
    check("ended start held", int'(start), 1);
    check("ended game_state", int'(game_state), 2);

    // One-cycle reset in ENDED with switch held; switch after release is dropped
    btn_switch = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_idle_outputs("mid-game reset");
    reset = 1'b1;
    tick(12);
    btn_switch = 1'b0;
    tick(4);
    check("post reset switch ignored game_state", int'(game_state), 0);

    // Start held through reset release yields exactly one event
    btn_start = 1'b1;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    expect_event(EV_START);
    tick(10);
    btn_start = 1'b0;
    tick(4);
    check("held-through-reset start", int'(game_state), 1);

    // Switch coinciding with p1 surrender: surrender wins
    btn_switch  = 1'b1;
    btn_surr_p1 = 1'b1;
    expect_event(EV_P1);
    tick(8);
    btn_switch  = 1'b0;
    btn_surr_p1 = 1'b0;
    tick(8);
    check("p1 over switch game_state", int'(game_state), 2);

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
